dmem_run_ctrl: RTL and testbench
================================

Name: dmem_run_ctrl

Overview:
- Run controller and data-memory arbiter for the RSA pipeline CPU.
- Shares the single-port data memory between a host loader and the CPU core. The host owns memory while the CPU is held; the CPU owns it while running.
- Drives the core's start input, detects program completion (CPU store to DONE_ADDR) or watchdog expiry, and returns memory ownership to the host so results can be read.

Parameters:
DONE_ADDR  32'h0000_0FFC  CPU store address that signals end of program
TIMEOUT    1000000        max RUN cycles before forced stop
CW         32             width of cycle_count

Ports:
clk          input   1   system clock
reset        input   1   synchronous, active-high reset
go           input   1   pulse: start CPU run (honoured in IDLE only)
clear        input   1   pulse: DONE -> IDLE
host_req     input   1   host access request, held high until host_ack
host_we      input   1   host write enable (valid with host_req)
host_addr    input   32  host byte address
host_wdata   input   32  host write data
host_rdata   output  32  host read data, valid with host_ack
host_ack     output  1   one-cycle access-complete pulse
cpu_memwrite input   1   core MemWrite
cpu_addr     input   32  core ALUResult (data address)
cpu_wdata    input   32  core WriteData
cpu_rdata    output  32  core ReadData
cpu_start    output  1   core start/enable
mem_we       output  1   memory write enable
mem_addr     output  32  memory address
mem_wdata    output  32  memory write data
mem_rdata    input   32  memory read data (synchronous, 1-cycle latency)
busy         output  1   high in RUN
done         output  1   high in DONE
timeout      output  1   high in DONE when the run ended by watchdog
cycle_count  output  CW  RUN cycles of last/current run

Behaviour:
- Reset (sync, checked every cycle, overrides everything including mid-run or mid-access):
  - state = IDLE.
  - cpu_start, busy, done, timeout, host_ack = 0; host_rdata = 0; cycle_count = 0.
- States: IDLE, IDLE_ACK, RUN, DONE, DONE_ACK.
- Host access (IDLE or DONE with host_req = 1):
  - Same cycle: mem_addr = host_addr, mem_wdata = host_wdata, mem_we = host_we.
  - Next state is the matching *_ACK state.
  - In *_ACK: host_ack = 1, host_rdata = mem_rdata (registered copy held until the next ack), mem_we = 0, then return to IDLE or DONE.
  - Throughput: one access per 2 cycles. host_req still high in the ack cycle is not sampled; it is a new request only from the following cycle.
- IDLE:
  - go = 1 with host_req = 0 -> RUN; cycle_count cleared to 0; timeout cleared.
  - go and host_req in the same cycle: host access wins, go is dropped and must be re-pulsed.
  - go in IDLE_ACK: ignored.
- RUN:
  - cpu_start = 1, busy = 1.
  - mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = cpu_memwrite.
  - host_req is not acknowledged (host waits) and host signals never reach memory.
  - cycle_count increments each RUN cycle and saturates at all-ones.
  - cpu_memwrite = 1 with cpu_addr == DONE_ADDR: the store is performed to memory in that cycle, then -> DONE next cycle; cpu_start = 0 from the DONE cycle.
  - cycle_count reaching TIMEOUT-1 with no done store -> DONE with timeout = 1.
  - Done store and timeout in the same cycle: timeout = 0 (done store wins).
  - go in RUN: ignored.
- DONE:
  - done = 1, cpu_start = 0; cycle_count and timeout hold.
  - Host accesses are served as in IDLE.
  - clear = 1 (not in DONE_ACK) -> IDLE; done cleared, cycle_count held until the next go.
  - clear and host_req in the same cycle: host access first, clear dropped.
- cpu_rdata = mem_rdata in all states.
- In non-RUN states with no host access: mem_we = 0; mem_addr / mem_wdata follow host inputs.
- All outputs except the mem_* mux and cpu_rdata are registered.

Test Plan:
1. Reset, then host writes 0xDEADBEEF to 0x100 (req, we=1) -> mem_we=1 in the req cycle, host_ack exactly 1 cycle later. Host then reads 0x100 -> host_rdata=0xDEADBEEF with ack.
2. go in IDLE -> cpu_start=1 next cycle. CPU stores 0x1 to 0x200 then 0x0 to 0xFFC at RUN cycle 10 -> both stores reach memory, done=1 the following cycle, cpu_start=0, cycle_count=10, timeout=0.
3. TIMEOUT=20, CPU never stores DONE_ADDR -> DONE after 20 RUN cycles with timeout=1 and cycle_count=20. clear -> IDLE.
4. host_req held high throughout RUN -> no host_ack and mem_we follows only cpu_memwrite. After DONE, host_ack arrives 1 cycle after the first DONE cycle.
5. go and host_req in the same IDLE cycle -> host access completes, state stays IDLE. A later lone go -> RUN.
6. reset asserted in RUN cycle 5, and again in IDLE_ACK -> next cycle IDLE with every output 0 and no host_ack pulse.

Source files
------------

// File: rtl/dmem_run_ctrl.sv
// dmem_run_ctrl: run controller and data-memory arbiter between a host loader and the CPU core
// Ports: clk/reset (sync, active high); go/clear run control pulses;
// host_req/we/addr/wdata -> host_rdata/host_ack (one access per two cycles, outside RUN);
// cpu_memwrite/addr/wdata -> cpu_rdata, cpu_start; mem_we/addr/wdata -> single-port memory, mem_rdata back (1-cycle latency);
// busy/done/timeout/cycle_count run status.
module dmem_run_ctrl #(
  parameter logic [31:0] DONE_ADDR = 32'h0000_0FFC,
  parameter int          TIMEOUT   = 1000000,
  parameter int          CW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          clear,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          host_ack,
  input  logic          cpu_memwrite,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_start,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);
  typedef enum logic [2:0] {IDLE, IDLE_ACK, RUN, DONE, DONE_ACK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic start_q, busy_q, done_q, ack_q;
  logic done_store;
  assign done_store = cpu_memwrite && (cpu_addr == DONE_ADDR);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          mem_we  = host_we;
          state_d = IDLE_ACK;
        end else if (go) begin
          state_d = RUN;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      IDLE_ACK: begin
        rdata_d = mem_rdata;
        state_d = IDLE;
      end
      RUN: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_memwrite;
        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // the done store beats a watchdog expiry landing in the same cycle
        if (done_store) begin
          state_d = DONE;
          tmo_d   = 1'b0;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        if (host_req) begin
          mem_we  = host_we;
          state_d = DONE_ACK;
        end else if (clear) begin
          state_d = IDLE;
        end
      end
      DONE_ACK: begin
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      start_q <= state_d == RUN;
      busy_q  <= state_d == RUN;
      done_q  <= state_d inside {DONE, DONE_ACK};
      ack_q   <= state_d inside {IDLE_ACK, DONE_ACK};
    end
  end
  // read data arrives from memory during the ack cycle; afterwards the captured copy is held
  assign host_rdata  = ack_q ? mem_rdata : rdata_q;
  assign host_ack    = ack_q;
  assign cpu_rdata   = mem_rdata;
  assign cpu_start   = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_dmem_run_ctrl.sv
// tb_dmem_run_ctrl: randomized and directed check of dmem_run_ctrl against a behavioural model
module tb_dmem_run_ctrl;
  localparam int T = 20;
  localparam logic [31:0] DA = 32'h0000_0FFC;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, go = 1'b0, clear = 1'b0, host_req = 1'b0, host_we = 1'b0, cpu_memwrite = 1'b0;
  logic [31:0] host_addr = '0, host_wdata = '0, cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] host_rdata, cpu_rdata, mem_addr, mem_wdata, cycle_count;
  logic [31:0] mem_rdata = '0;
  logic host_ack, cpu_start, mem_we, busy, done, timeout;
  logic mem_init = 1'b1;
  logic [31:0] mem [0:1023];
  int n_cmp = 0, n_err = 0;
  dmem_run_ctrl #(.DONE_ADDR(DA), .TIMEOUT(T), .CW(32)) dut (
    .clk(clk), .reset(reset), .go(go), .clear(clear),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_start(cpu_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[11:2]];
    end
  end
  // behavioural model: who owns memory, whether a run has finished, pending ack
  bit m_run, m_fin, m_ack, m_tmo;
  int unsigned m_cnt;
  logic [31:0] m_held, m_pend, m_prev;
  logic [31:0] ref_mem [0:1023];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rnd_addr();
    logic [9:0] w = 10'($urandom_range(0, 1023));
    return {20'd0, w, 2'b00};
  endfunction
  task automatic step(input logic r, g, c, rq, hwe, input logic [31:0] ha, hw,
                      input logic mw, input logic [31:0] ca, cw);
    logic [31:0] e_addr, e_wdata, rd;
    logic e_we;
    reset = r; go = g; clear = c; host_req = rq; host_we = hwe; host_addr = ha; host_wdata = hw;
    cpu_memwrite = mw; cpu_addr = ca; cpu_wdata = cw;
    @(negedge clk);
    e_addr  = m_run ? ca : ha;
    e_wdata = m_run ? cw : hw;
    e_we    = m_run ? mw : (!m_ack && rq && hwe);
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rdata", cpu_rdata, m_prev);
    chk("host_rdata", host_rdata, m_ack ? m_pend : m_held);
    chk("host_ack", {31'd0, host_ack}, {31'd0, m_ack});
    chk("cpu_start", {31'd0, cpu_start}, {31'd0, m_run});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("done", {31'd0, done}, {31'd0, m_fin});
    chk("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    chk("cycle_count", cycle_count, m_cnt);
    rd = ref_mem[e_addr[11:2]];
    if (e_we) ref_mem[e_addr[11:2]] = e_wdata;
    m_prev = rd;
    if (r) begin
      m_run = 0; m_fin = 0; m_ack = 0; m_tmo = 0; m_cnt = 0; m_held = '0;
    end else if (m_ack) begin
      m_held = m_pend; m_ack = 0;
    end else if (m_run) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (mw && ca == DA) begin
        m_run = 0; m_fin = 1; m_tmo = 0;
      end else if (m_cnt >= T) begin
        m_run = 0; m_fin = 1; m_tmo = 1;
      end
    end else if (rq) begin
      m_ack = 1; m_pend = rd;
    end else if (!m_fin && g) begin
      m_run = 1; m_cnt = 0; m_tmo = 0;
    end else if (m_fin && c) m_fin = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rnd_addr(), $urandom, 0, rnd_addr(), $urandom);
  endtask
  task automatic hacc(input logic we, input logic [31:0] a, d);
    step(0, 0, 0, 1, we, a, d, 0, '0, '0);
    step(0, 0, 0, 1, we, a, d, 0, '0, '0);
  endtask
  task automatic run_cycle(input logic mw, input logic [31:0] ca, cw);
    step(0, 0, 0, 0, 0, rnd_addr(), $urandom, mw, ca, cw);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    m_run = 0; m_fin = 0; m_ack = 0; m_tmo = 0; m_cnt = 0; m_held = '0; m_pend = '0; m_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", cycle_count, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    // host write then read back
    hacc(1, 32'h100, 32'hDEADBEEF);
    hacc(0, 32'h100, 32'h0);
    chk("t1_rdata_held", host_rdata, 32'hDEADBEEF);
    // normal run ending with a done store at RUN cycle 10
    step(0, 1, 0, 0, 0, '0, '0, 0, '0, '0);
    chk("t2_start", {31'd0, cpu_start}, 32'd1);
    for (int k = 1; k <= 10; k++)
      run_cycle(k == 3 || k == 10, k == 10 ? DA : (k == 3 ? 32'h200 : rnd_addr()), k == 3 ? 32'h1 : 32'h0);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_start_off", {31'd0, cpu_start}, 32'd0);
    chk("t2_cnt", cycle_count, 32'd10);
    chk("t2_tmo", {31'd0, timeout}, 32'd0);
    hacc(0, 32'h200, '0);
    chk("t2_store", host_rdata, 32'h1);
    step(0, 0, 1, 0, 0, '0, '0, 0, '0, '0);
    // watchdog expiry
    step(0, 1, 0, 0, 0, '0, '0, 0, '0, '0);
    for (int k = 1; k <= T; k++) run_cycle(0, rnd_addr(), $urandom);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_tmo", {31'd0, timeout}, 32'd1);
    chk("t3_cnt", cycle_count, T);
    step(0, 0, 1, 0, 0, '0, '0, 0, '0, '0);
    chk("t3_cleared", {31'd0, done}, 32'd0);
    chk("t3_cnt_held", cycle_count, T);
    // host held off during RUN
    step(0, 1, 0, 0, 0, '0, '0, 0, '0, '0);
    for (int k = 1; k <= 12; k++)
      step(0, 0, 0, 1, 1, 32'h300, 32'hBAD0BAD0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
    step(0, 0, 0, 1, 1, 32'h300, 32'hBAD0BAD0, 1, DA, 32'h0);
    chk("t4_no_ack", {31'd0, host_ack}, 32'd0);
    step(0, 0, 0, 1, 1, 32'h300, 32'hBAD0BAD0, 0, '0, '0);
    chk("t4_ack", {31'd0, host_ack}, 32'd1);
    step(0, 0, 0, 1, 1, 32'h300, 32'hBAD0BAD0, 0, '0, '0);
    step(0, 0, 1, 0, 0, '0, '0, 0, '0, '0);
    // go colliding with host_req
    step(0, 1, 0, 1, 0, 32'h100, '0, 0, '0, '0);
    step(0, 0, 0, 1, 0, 32'h100, '0, 0, '0, '0);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    idle(1);
    chk("t5_still_idle", {31'd0, busy}, 32'd0);
    step(0, 1, 0, 0, 0, '0, '0, 0, '0, '0);
    chk("t5_run", {31'd0, busy}, 32'd1);
    run_cycle(1, DA, 32'h5);
    step(0, 0, 1, 0, 0, '0, '0, 0, '0, '0);
    // reset mid-run and mid-ack
    step(0, 1, 0, 0, 0, '0, '0, 0, '0, '0);
    for (int k = 1; k <= 4; k++) run_cycle(0, rnd_addr(), $urandom);
    step(1, 0, 0, 0, 0, '0, '0, 1, 32'h40, 32'h77);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_start", {31'd0, cpu_start}, 32'd0);
    chk("t6_cnt", cycle_count, 32'd0);
    hacc(0, 32'h100, '0);
    step(0, 0, 0, 1, 0, 32'h100, '0, 0, '0, '0);
    step(1, 0, 0, 1, 0, 32'h100, '0, 0, '0, '0);
    chk("t6_no_ack", {31'd0, host_ack}, 32'd0);
    chk("t6_rdata", host_rdata, 32'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ca;
      ca = ($urandom_range(0, 15) == 0) ? DA : rnd_addr();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
           $urandom_range(0, 2) == 0, ca, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
